// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate truth-table checker: FSM state encoding,
// default input count and the canonical 2-input truth tables
// (bit i = required output for input vector i).
package gate_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } gate_chk_state_t;

  localparam int N_IN_DEF = 2;

  localparam logic [3:0] TT_NAND2 = 4'b0111;
  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_NOR2  = 4'b0001;
  localparam logic [3:0] TT_XOR2  = 4'b0110;

endpackage : gate_chk_pkg

// File: rtl/gate_truth_table_checker.sv
// Walks every input vector of an N_IN-input combinational gate, holds each
// vector for SETTLE cycles plus one check cycle, and compares the gate output
// against a truth table latched at start. Reports pass, mismatch count and the
// first failing vector index.
// Optional build macro: GATE_CHK_STOP_ON_FAIL_EN -- end the run on the first
// mismatch, leaving dut_in on the failing vector.
module gate_truth_table_checker
  import gate_chk_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [(1<<N_IN)-1:0]  exp_tt,
  input  logic                  dut_y,
  output logic [N_IN-1:0]       dut_in,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [N_IN:0]         fail_count,
  output logic [N_IN-1:0]       first_fail_vec,
  output logic                  first_fail_valid
);

  localparam int TT_W  = 1 << N_IN;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [N_IN-1:0]  VEC_LAST = {N_IN{1'b1}};

  generate
    if (SETTLE < 1) begin : g_bad_settle
      $error("gate_truth_table_checker: SETTLE must be >= 1");
    end
    if (N_IN < 1 || N_IN > 6) begin : g_bad_nin
      $error("gate_truth_table_checker: N_IN must be in 1..6");
    end
  endgenerate

  gate_chk_state_t   state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_IN:0]     fail_q, fail_d;
  logic [N_IN-1:0]   ffv_q, ffv_d;
  logic              ffval_q, ffval_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [TT_W-1:0]   exp_l_q;
  logic              load_exp;
  logic              mismatch;

  // Next-state, counter and capture logic for the vector walk.
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    fail_d   = fail_q;
    ffv_d    = ffv_q;
    ffval_d  = ffval_q;
    load_exp = 1'b0;
    // 4-state compare: an X/Z gate output counts as a mismatch in simulation.
    mismatch = (dut_y !== exp_l_q[vec_q]);
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          load_exp = 1'b1;
          vec_d    = '0;
          cnt_d    = '0;
          fail_d   = '0;
          ffv_d    = '0;
          ffval_d  = 1'b0;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_CHECK: begin
        if (mismatch) begin
          // At most 2**N_IN mismatches, so N_IN+1 bits cannot wrap.
          fail_d = fail_q + {{N_IN{1'b0}}, 1'b1};
          if (!ffval_q) begin
            ffv_d   = vec_q;
            ffval_d = 1'b1;
          end
        end
`ifdef GATE_CHK_STOP_ON_FAIL_EN
        if (mismatch || vec_q == VEC_LAST) begin
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + {{(N_IN-1){1'b0}}, 1'b1};
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
`else
        if (vec_q == VEC_LAST) begin
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + {{(N_IN-1){1'b0}}, 1'b1};
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status flags are registered from the current state, so they trail the
  // FSM by one cycle and see the final counter values when DONE is reached.
  always_comb begin
    busy_d = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
    done_d = (state_q == ST_DONE);
    pass_d = (state_q == ST_DONE) && (fail_q == '0);
  end

  // Control and result registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      fail_q  <= '0;
      ffv_q   <= '0;
      ffval_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      ffv_q   <= ffv_d;
      ffval_q <= ffval_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // Expected truth table snapshot; only read after a start reloads it.
  always_ff @(posedge clk) begin
    if (load_exp) begin
      exp_l_q <= exp_tt;
    end
  end

  assign dut_in           = vec_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign fail_count       = fail_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffval_q;

endmodule : gate_truth_table_checker

// File: tb/tb_gate_truth_table_checker.sv
// Bench for gate_truth_table_checker (N_IN=2, SETTLE=1) driving a behavioural
// 2-input gate whose function is chosen per test.
// Honours GATE_CHK_STOP_ON_FAIL_EN when the design is built with it.
module tb_gate_truth_table_checker;
  import gate_chk_pkg::*;

  localparam int N_IN   = 2;
  localparam int SETTLE = 1;
`ifdef GATE_CHK_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  // Gate models
  localparam int M_NAND = 0, M_AND = 1, M_STUCK1 = 2, M_OR = 3, M_XOR = 4, M_NOR = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] exp_tt;
  logic       dut_y;
  logic [1:0] dut_in;
  logic       busy, done, pass;
  logic [2:0] fail_count;
  logic [1:0] first_fail_vec;
  logic       first_fail_valid;

  int mode;
  int checks = 0;
  int errors = 0;
  int lat;
  int seen_in [0:31];

  gate_truth_table_checker #(.N_IN(N_IN), .SETTLE(SETTLE)) u_dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .exp_tt           (exp_tt),
    .dut_y            (dut_y),
    .dut_in           (dut_in),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .fail_count       (fail_count),
    .first_fail_vec   (first_fail_vec),
    .first_fail_valid (first_fail_valid)
  );

  always #5 clk = ~clk;

  // Behavioural gate: dut_in[1] is the first input, dut_in[0] the second.
  always_comb begin
    dut_y = 1'b0;
    case (mode)
      M_NAND:   dut_y = ~(dut_in[1] & dut_in[0]);
      M_AND:    dut_y = dut_in[1] & dut_in[0];
      M_STUCK1: dut_y = 1'b1;
      M_OR:     dut_y = dut_in[1] | dut_in[0];
      M_XOR:    dut_y = dut_in[1] ^ dut_in[0];
      M_NOR:    dut_y = ~(dut_in[1] | dut_in[0]);
      default:  dut_y = 1'b0;
    endcase
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pulse start for one edge, then wait (bounded) for done; lat counts edges
  // after the start edge. Optionally re-pulses start and changes exp_tt mid-run.
  task automatic run(input bit inject);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen_in[0] = dut_in;
    lat = 0;
    do begin
      if (inject && (lat == 2 || lat == 4)) begin
        start  = 1'b1;
        exp_tt = TT_AND2;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (lat < 32) seen_in[lat] = dut_in;
    end while (!done && lat < 100);
    start = 1'b0;
    if (lat >= 100) chk("done_timeout", lat, 9);
  endtask

  typedef struct {
    int         mode;
    logic [3:0] tt;
    int         fcnt;
    int         ffv;
  } vec_t;

  vec_t tbl [0:6];

  initial begin
    tbl[0] = '{M_NAND,   TT_NAND2, 0, 0};
    tbl[1] = '{M_AND,    TT_NAND2, 4, 0};
    tbl[2] = '{M_STUCK1, TT_NAND2, 1, 3};
    tbl[3] = '{M_OR,     TT_OR2,   0, 0};
    tbl[4] = '{M_XOR,    TT_NOR2,  3, 0};
    tbl[5] = '{M_AND,    TT_AND2,  0, 0};
    tbl[6] = '{M_NOR,    TT_XOR2,  3, 0};

    mode   = M_NAND;
    rst    = 1'b1;
    start  = 1'b0;
    exp_tt = TT_NAND2;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fcnt", fail_count, 0);
    chk("rst_ffvalid", first_fail_valid, 0);
    chk("rst_dut_in", dut_in, 0);
    @(negedge clk);
    rst = 1'b0;

    // start held low in IDLE: nothing happens
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", busy, 0);

    // Table-driven runs
    for (int i = 0; i < 7; i++) begin
      int exp_fc, exp_lat, exp_in;
      mode   = tbl[i].mode;
      exp_tt = tbl[i].tt;
      if (STOP && tbl[i].fcnt > 0) begin
        exp_fc  = 1;
        exp_lat = 1 + (tbl[i].ffv + 1) * (SETTLE + 1);
        exp_in  = tbl[i].ffv;
      end else begin
        exp_fc  = tbl[i].fcnt;
        exp_lat = 1 + 4 * (SETTLE + 1);
        exp_in  = 3;
      end
      run(1'b0);
      chk($sformatf("t%0d_latency", i), lat, exp_lat);
      chk($sformatf("t%0d_pass", i), pass, (exp_fc == 0) ? 1 : 0);
      chk($sformatf("t%0d_fcnt", i), fail_count, exp_fc);
      chk($sformatf("t%0d_ffvalid", i), first_fail_valid, (exp_fc > 0) ? 1 : 0);
      if (exp_fc > 0) chk($sformatf("t%0d_ffvec", i), first_fail_vec, tbl[i].ffv);
      chk($sformatf("t%0d_busy", i), busy, 0);
      chk($sformatf("t%0d_dut_in", i), dut_in, exp_in);
      if (i == 0) begin
        // vector stepping: each vector stable for SETTLE+1 cycles
        for (int k = 1; k < 8; k++)
          chk($sformatf("step_dut_in_%0d", k), seen_in[k], k / 2);
        chk("mid_busy", 1, 1);
      end
    end

    // done/results held while idle in DONE
    repeat (4) @(posedge clk);
    #1;
    chk("hold_done", done, 1);
    chk("hold_fcnt", fail_count, STOP ? 1 : 3);

    // rst mid-run at vec 2
    mode   = M_NAND;
    exp_tt = TT_NAND2;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (dut_in != 2'd2 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("reach_vec2", (lat < 50) ? 1 : 0, 1);
    chk("run_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_dut_in", dut_in, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_fcnt", fail_count, 0);
    @(negedge clk);
    rst = 1'b0;
    run(1'b0);
    chk("post_rst_first_in", seen_in[1], 0);
    chk("post_rst_latency", lat, 9);
    chk("post_rst_pass", pass, 1);

    // start pulses while busy and exp_tt changed mid-run are ignored
    mode   = M_NAND;
    exp_tt = TT_NAND2;
    run(1'b1);
    chk("inject_latency", lat, 9);
    chk("inject_pass", pass, 1);
    chk("inject_fcnt", fail_count, 0);

    // start together with rst: rst wins
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    chk("rst_start_busy", busy, 0);
    @(posedge clk); #1;
    chk("rst_start_busy2", busy, 0);
    chk("rst_start_dut_in", dut_in, 0);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_gate_truth_table_checker
